// File: rtl/hash160_pkg.sv
// Shared definitions for the Hash160 input path.
//   START_BYTE  : frame-start marker seen by the byte framer
//   BLOCK_BYTES : payload bytes per SHA-256 message block
//   BLOCK_W     : packed block width in bits
//   CNT_W       : width of the framer byte counter
//   framer_state_t : framer FSM encoding {IDLE, COLLECT, HOLD}
package hash160_pkg;

    localparam logic [7:0] START_BYTE  = 8'hAA;
    localparam int         BLOCK_BYTES = 64;
    localparam int         BLOCK_W     = 8 * BLOCK_BYTES;
    localparam int         CNT_W       = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } framer_state_t;

endpackage

// File: rtl/hash_input_framer.sv
// Byte-serial input framer for the Hash160 datapath.
// Waits in IDLE for START_BYTE, then shifts the next BLOCK_BYTES bytes
// MSB-first into a message block and holds it until the hash core takes it.
//   clk           : rising-edge clock
//   rst_n         : asynchronous active-low reset
//   i_text        : byte input, sampled every edge
//   o_block       : packed block, first payload byte in the top byte
//   o_block_valid : block complete and stable (HOLD)
//   i_block_ready : downstream accept; transfer on valid && ready
//   o_busy        : frame in progress or waiting for transfer
module hash_input_framer #(
    parameter logic [7:0] START_BYTE  = 8'hAA,
    parameter int         BLOCK_BYTES = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 i_text,
    output logic [8*BLOCK_BYTES-1:0]   o_block,
    output logic                       o_block_valid,
    input  logic                       i_block_ready,
    output logic                       o_busy
);

    import hash160_pkg::*;

    localparam int BLK_W    = 8 * BLOCK_BYTES;
    localparam int CNT_BITS = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;

    framer_state_t         state_q;
    framer_state_t         state_d;
    logic [CNT_BITS-1:0]   cnt_q;
    logic                  last_byte;

    assign last_byte = (cnt_q == CNT_BITS'(BLOCK_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Start bytes are only meaningful in IDLE; in COLLECT they are payload
    // and in HOLD every input byte is dropped.
    always_comb begin
        state_d       = state_q;
        o_block_valid = 1'b0;
        o_busy        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_text == START_BYTE) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                o_busy = 1'b1;
                if (last_byte) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                o_busy        = 1'b1;
                o_block_valid = 1'b1;
                if (i_block_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Counter wraps to zero on the last byte, so it is already clear for
    // the next frame; it is also cleared on start for robustness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            if (i_text == START_BYTE) begin
                cnt_q <= '0;
            end
        end else if (state_q == COLLECT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Block only moves in COLLECT: frozen while valid, kept after transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_block <= '0;
        end else if (state_q == COLLECT) begin
            o_block <= {o_block[BLK_W-9:0], i_text};
        end
    end

endmodule

// File: tb/tb_hash_input_framer.sv
module tb_hash_input_framer;

    import hash160_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   i_text;
    logic [511:0] o_block;
    logic         o_block_valid;
    logic         i_block_ready;
    logic         o_busy;

    int n_assert = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    int n_valid  = 0;

    logic [511:0] exp_q[$];

    always #5 clk = ~clk;

    hash_input_framer #(
        .START_BYTE  (8'hAA),
        .BLOCK_BYTES (64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_text        (i_text),
        .o_block       (o_block),
        .o_block_valid (o_block_valid),
        .i_block_ready (i_block_ready),
        .o_busy        (o_busy)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one byte mid-cycle; the following rising edge samples it.
    // A handshake visible now completes on that edge, so the block is
    // scored against the oldest expected frame here.
    task automatic step(input logic [7:0] b, input logic r);
        @(negedge clk);
        i_text        = b;
        i_block_ready = r;
        #1;
        if (o_block_valid) n_valid++;
        if (o_block_valid && i_block_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                chk("unexpected_transfer", 512'd1, 512'd0);
            end else begin
                chk("xfer_block", o_block, exp_q.pop_front());
            end
        end
    endtask

    // Start byte plus 64 payload bytes; bytes are first+k (k=0..63) or all fill.
    task automatic send_frame(input logic [7:0] first, input logic use_fill,
                              input logic [7:0] fill, input logic r);
        logic [511:0] blk;
        logic [7:0]   b;
        blk = '0;
        step(8'hAA, r);
        for (int k = 0; k < 64; k++) begin
            b   = use_fill ? fill : first + 8'(k);
            blk = {blk[503:0], b};
        end
        exp_q.push_back(blk);
        for (int k = 0; k < 64; k++) begin
            b = use_fill ? fill : first + 8'(k);
            step(b, r);
        end
    endtask

    logic [511:0] ramp;
    int           v0;

    initial begin
        for (int k = 0; k < 64; k++) ramp[511-8*k -: 8] = 8'(k);

        // 1: reset with random input
        rst_n = 1'b0;
        i_block_ready = 1'b0;
        i_text = 8'h00;
        repeat (2) begin
            @(negedge clk);
            i_text = 8'($urandom_range(0, 255));
        end
        #1;
        chk("rst_block", o_block, 512'd0);
        chk("rst_valid", {511'd0, o_block_valid}, 512'd0);
        chk("rst_busy",  {511'd0, o_busy}, 512'd0);
        chk("rst_state", {510'd0, dut.state_q}, {510'd0, IDLE});
        @(negedge clk);
        rst_n = 1'b1;

        // 2: basic frame with ready high throughout
        v0 = n_valid;
        send_frame(8'h00, 1'b0, 8'h00, 1'b1);
        chk("basic_no_early_valid", 512'(n_valid - v0), 512'd0);
        step(8'h00, 1'b1);
        chk("basic_valid_after_e64", {511'd0, o_block_valid}, 512'd1);
        chk("basic_block_literal", o_block, ramp);
        step(8'h00, 1'b1);
        chk("basic_valid_dropped", {511'd0, o_block_valid}, 512'd0);
        chk("basic_busy_dropped",  {511'd0, o_busy}, 512'd0);
        chk("basic_one_valid_cycle", 512'(n_valid - v0), 512'd1);

        // 3: back-pressure with toggling input including start bytes
        send_frame(8'h00, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step((k % 2 == 0) ? 8'hAA : 8'h5A, 1'b0);
            chk("bp_valid_held", {511'd0, o_block_valid}, 512'd1);
            chk("bp_block_frozen", o_block, ramp);
        end
        step(8'hAA, 1'b1);   // transfer edge; start byte here must be ignored
        step(8'h33, 1'b0);
        chk("bp_state_idle", {510'd0, dut.state_q}, {510'd0, IDLE});
        chk("bp_busy_low",   {511'd0, o_busy}, 512'd0);
        chk("bp_block_kept", o_block, ramp);

        // 4: start byte as payload
        send_frame(8'h00, 1'b1, 8'hAA, 1'b1);
        step(8'h00, 1'b1);
        chk("aa_block", o_block, {64{8'hAA}});
        step(8'h00, 1'b0);
        chk("aa_busy_low", {511'd0, o_busy}, 512'd0);

        // 5: idle noise
        v0 = n_valid;
        for (int k = 0; k < 20; k++) begin
            step((k % 3 == 0) ? 8'h55 : (k % 3 == 1) ? 8'hAB : 8'h00, k[0]);
            chk("noise_busy", {511'd0, o_busy}, 512'd0);
        end
        chk("noise_no_valid", 512'(n_valid - v0), 512'd0);

        // 6: mid-frame reset then recovery
        step(8'hAA, 1'b0);
        for (int k = 0; k < 30; k++) step(8'hC0 + 8'(k), 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_block", o_block, 512'd0);
        chk("midrst_busy",  {511'd0, o_busy}, 512'd0);
        chk("midrst_state", {510'd0, dut.state_q}, {510'd0, IDLE});
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h00, 1'b0, 8'h00, 1'b0);
        step(8'h00, 1'b0);
        chk("recover_block", o_block, ramp);
        step(8'h00, 1'b1);
        step(8'h00, 1'b0);

        chk("all_frames_scored", 512'(exp_q.size()), 512'd0);
        chk("transfer_count", 512'(n_xfer), 512'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
